// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one main-memory block port between I-cache refill and D-cache miss/write-back.
// Define MEM_ARB_FAIRNESS_EN to cap consecutive D grants while the I-side waits.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 28,
    parameter int DATA_WIDTH   = 128,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_e;

    if (MAX_D_STREAK < 1) begin : g_bad_streak
        $error("MAX_D_STREAK must be at least 1");
    end

    state_e                state_q, state_d;
    logic                  started_q, started_d;
    logic                  rel_d_q, rel_d_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                  d_req, serve_i, serve_d, done, i_done, d_done, grant_i;

    assign d_req   = D_READ | D_WRITE;
    assign serve_i = state_q == SERVE_I;
    assign serve_d = state_q == SERVE_D;
    assign done    = started_q && !MEM_BUSYWAIT;
    assign i_done  = serve_i && I_READ && done;
    assign d_done  = serve_d && d_req && done;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    logic [SW-1:0] streak_q, streak_d;
    assign grant_i  = I_READ && (!d_req || streak_q == SW'(MAX_D_STREAK));
    assign streak_d = i_done ? '0 : d_done ? (I_READ ? streak_q + 1'b1 : '0) : streak_q;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) streak_q <= '0;
        else        streak_q <= streak_d;
    end
`else
    assign grant_i = I_READ && !d_req;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            rel_d_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            rel_d_q   <= rel_d_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // A request dropped mid-serve is illegal; abandon it without a RELEASE cycle.
    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        rel_d_d   = rel_d_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE:    state_d = grant_i ? SERVE_I : d_req ? SERVE_D : IDLE;
            SERVE_I: begin
                started_d = I_READ && !done;
                if (!I_READ) state_d = IDLE;
                else if (done) begin
                    state_d   = RELEASE;
                    rel_d_d   = 1'b0;
                    i_rdata_d = MEM_READDATA;
                end
            end
            SERVE_D: begin
                started_d = d_req && !done;
                if (!d_req) state_d = IDLE;
                else if (done) begin
                    state_d   = RELEASE;
                    rel_d_d   = 1'b1;
                    d_rdata_d = D_WRITE ? d_rdata_q : MEM_READDATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MEM_READ      = serve_i ? I_READ : serve_d && D_READ && !D_WRITE;
    assign MEM_WRITE     = serve_d && D_WRITE;
    assign MEM_ADDRESS   = serve_i ? I_ADDRESS : serve_d ? D_ADDRESS : '0;
    assign MEM_WRITEDATA = serve_d ? D_WRITEDATA : '0;
    assign I_READDATA    = i_rdata_q;
    assign D_READDATA    = d_rdata_q;
    // Only the side just released sees busywait low in RELEASE; the other keeps stalling.
    assign I_BUSYWAIT    = I_READ && !i_done && !(state_q == RELEASE && !rel_d_q);
    assign D_BUSYWAIT    = d_req && !d_done && !(state_q == RELEASE && rel_d_q);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table-driven bench for mem_bus_arbiter with a latency-programmable memory model.
module tb_mem_bus_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam logic [AW-1:0] IA = 28'h0000010;
    localparam logic [AW-1:0] DA = 28'h0000020;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata, d_wdata;
    logic          i_bw, d_bw, mem_rd, mem_wr, mem_bw;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mcnt = '0;
    int            lat = 5;
    int            checks = 0, errors = 0;

    mem_bus_arbiter dut (
        .CLK(clk), .RESET(rst_n),
        .I_READ(i_read), .I_ADDRESS(IA), .I_READDATA(i_rdata), .I_BUSYWAIT(i_bw),
        .D_READ(d_read), .D_WRITE(d_write), .D_ADDRESS(DA), .D_WRITEDATA(d_wdata),
        .D_READDATA(d_rdata), .D_BUSYWAIT(d_bw),
        .MEM_READ(mem_rd), .MEM_WRITE(mem_wr), .MEM_ADDRESS(mem_addr),
        .MEM_WRITEDATA(mem_wdata), .MEM_READDATA(mem_rdata), .MEM_BUSYWAIT(mem_bw)
    );

    always #5 clk = ~clk;

    // Memory stays busy for `lat` cycles after a strobe first appears.
    always @(posedge clk) mcnt <= (mem_rd | mem_wr) ? mcnt + 8'd1 : 8'd0;
    assign mem_bw = (mem_rd | mem_wr) && (int'(mcnt) < lat);

    typedef struct {
        logic          i_rd, d_rd, d_wr, e_rd, e_wr, e_ibw, e_dbw, e_wd;
        logic [AW-1:0] e_addr;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [2:0] in, input logic [3:0] ex, input logic [AW-1:0] a, input logic wd);
        tbl.push_back('{in[2], in[1], in[0], ex[3], ex[2], ex[1], ex[0], wd, a});
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int n, bad, ng;
        logic prev, s;
        logic [5:0] g, g_exp;
        d_wdata   = {4{32'hDEAD_BEEF}};
        mem_rdata = {16{8'hA5}};
        // Single I read, then simultaneous I read + D write-back (memory latency 5).
        add(3'b100, 4'b0010, '0, 0);
        for (int k = 1; k <= 5; k++) add(3'b100, 4'b1010, IA, 0);
        add(3'b100, 4'b1000, IA, 0);
        add(3'b000, 4'b0000, '0, 0);
        add(3'b101, 4'b0011, '0, 0);
        for (int k = 9; k <= 13; k++) add(3'b101, 4'b0111, DA, 1);
        add(3'b101, 4'b0110, DA, 1);
        add(3'b100, 4'b0010, '0, 0);
        add(3'b100, 4'b0010, '0, 0);
        for (int k = 17; k <= 21; k++) add(3'b100, 4'b1010, IA, 0);
        add(3'b100, 4'b1000, IA, 0);
        add(3'b000, 4'b0000, '0, 0);
        add(3'b000, 4'b0000, '0, 0);

        i_read = 1'b1;
        #1;
        chk("reset_state", {mem_rd, mem_wr, mem_addr, mem_wdata, i_rdata, d_rdata, i_bw, d_bw},
            {1'b0, 1'b0, 28'h0, 128'h0, 128'h0, 128'h0, 1'b1, 1'b0});
        repeat (2) @(negedge clk);
        i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            {i_read, d_read, d_write} = {tbl[k].i_rd, tbl[k].d_rd, tbl[k].d_wr};
            #1;
            chk($sformatf("row%0d", k), {mem_rd, mem_wr, i_bw, d_bw, mem_addr, mem_wdata},
                {tbl[k].e_rd, tbl[k].e_wr, tbl[k].e_ibw, tbl[k].e_dbw, tbl[k].e_addr,
                 tbl[k].e_wd ? d_wdata : 128'h0});
        end
        chk("i_rdata_a5", i_rdata, {16{8'hA5}});
        chk("d_rdata_after_write", d_rdata, 128'h0);

        // No-wait memory: completion on the second SERVE cycle.
        lat = 0; mem_rdata = {16{8'h5A}};
        @(negedge clk); d_read = 1'b1; #1;
        chk("lat1_idle", {mem_rd, d_bw}, 2'b01);
        @(negedge clk); #1;
        chk("lat1_serve1", {mem_rd, d_bw}, 2'b11);
        @(negedge clk); #1;
        chk("lat1_serve2", {mem_rd, d_bw}, 2'b10);
        @(negedge clk); d_read = 1'b0; #1;
        chk("lat1_data", {mem_rd, d_rdata}, {1'b0, {16{8'h5A}}});

        // D_READ and D_WRITE together is a write; read data untouched.
        lat = 2; mem_rdata = {16{8'h33}};
        @(negedge clk); d_read = 1'b1; d_write = 1'b1;
        n = 0; bad = 0; #1;
        while (d_bw && n < 20) begin
            if (mem_rd || (mem_addr == DA && !mem_wr)) bad++;
            @(negedge clk); #1; n++;
        end
        chk("rw_timeout", n < 20, 1'b1);
        chk("rw_only_write", {bad, mem_rd, mem_wr, mem_addr}, {32'd0, 1'b0, 1'b1, DA});
        @(negedge clk); d_read = 1'b0; d_write = 1'b0; #1;
        chk("rw_rdata_kept", d_rdata, {16{8'h5A}});

        // Asynchronous reset during SERVE_D, then full-latency re-serve.
        lat = 5; mem_rdata = {16{8'hC3}};
        @(negedge clk); @(negedge clk); d_read = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        chk("pre_reset_strobe", mem_rd, 1'b1);
        #1 rst_n = 1'b0; #1;
        chk("reset_abort", {mem_rd, mem_wr, mem_addr, d_rdata, d_bw}, {1'b0, 1'b0, 28'h0, 128'h0, 1'b1});
        @(negedge clk); rst_n = 1'b1;
        n = 0; #1;
        while (d_bw && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("reserve_latency", n, 6);
        @(negedge clk); d_read = 1'b0; #1;
        chk("reserve_data", d_rdata, {16{8'hC3}});

        // Continuous D plus I requests: grant order.
        lat = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; d_read = 1'b1; i_read = 1'b1;
        prev = 1'b0; ng = 0; g = '0;
        for (int c = 0; c < 40; c++) begin
            #1;
            s = mem_rd | mem_wr;
            if (s && !prev && ng < 6) begin
                g[ng] = (mem_addr == IA);
                ng++;
            end
            prev = s;
            @(negedge clk);
        end
        d_read = 1'b0; i_read = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
        g_exp = 6'b010000;
`else
        g_exp = 6'b000000;
`endif
        chk("grant_order", {ng, g}, {32'd6, g_exp});
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
